// File: rtl/fifo_sync_param.sv
// Parametrised synchronous first-word-fall-through FIFO with occupancy count,
// programmable almost-full/almost-empty flags, flush and sticky error flags.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     outputFinished,
  input  logic                     flush,
  input  logic                     clearErr,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     fifoFull,
  output logic                     fifoEmpty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_pushReject;
  logic w_popReject;

  // Acceptance uses the pre-edge flags; a pop frees the slot a full-FIFO push needs.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = outputFinished && !w_empty;
  assign w_push       = enable && (!w_full || w_pop);
  assign w_pushReject = enable && !w_push;
  assign w_popReject  = outputFinished && w_empty;

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_mem[r_wrPtr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
        if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      // A new error in the same cycle as clearErr must leave the flag set.
      if (clearErr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (!flush && w_pushReject) r_overflow  <= 1'b1;
      if (!flush && w_popReject)  r_underflow <= 1'b1;
    end
  end

  assign dataOut     = r_mem[r_rdPtr];
  assign fifoFull    = w_full;
  assign fifoEmpty   = w_empty;
  assign almostFull  = (r_count >= CW'(AF_LEVEL));
  assign almostEmpty = (r_count <= CW'(AE_LEVEL));
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
